// File: rtl/bp_dram_link_responder.sv
// bp_dram_link_responder: memory-side endpoint of the DRAM link.
// Accepts command packets on a ready-and link, executes them against an
// internal word-addressed store, and returns response packets.
module bp_dram_link_responder #(
  parameter int flit_width_p  = 64,
  parameter int addr_width_p  = 40,
  parameter int els_p         = 1024,
  parameter int link_width_lp = flit_width_p + 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [link_width_lp-1:0] cmd_link_i,
  output logic [link_width_lp-1:0] cmd_link_o,
  output logic [link_width_lp-1:0] resp_link_o,
  input  logic [link_width_lp-1:0] resp_link_i
);

  localparam int lg_els_lp   = $clog2(els_p);
  localparam int byte_off_lp = $clog2(flit_width_p / 8);

  typedef enum logic [2:0] {
    e_ready,
    e_wr_data,
    e_resp_hdr,
    e_rd_req,
    e_rd_data
  } state_e;

  typedef enum logic [1:0] {
    e_op_read  = 2'd0,
    e_op_write = 2'd1,
    e_op_ill2  = 2'd2,
    e_op_ill3  = 2'd3
  } op_e;

  state_e state_r, state_n;

  // Link unpacking: {v, data, ready_and_rev}
  logic                    cmd_v;
  logic [flit_width_p-1:0] cmd_data;
  logic                    resp_ready;

  assign cmd_v      = cmd_link_i[link_width_lp-1];
  assign cmd_data   = cmd_link_i[flit_width_p:1];
  assign resp_ready = resp_link_i[0];

  // Ready on the command side and data on the response side are unused
  logic unused_link;
  assign unused_link = ^{cmd_link_i[0], resp_link_i[link_width_lp-1:1]};

  // Header field extraction from the incoming flit
  logic [addr_width_p-1:0] hdr_addr;
  op_e                     hdr_op;
  logic [2:0]              hdr_len;

  assign hdr_addr = cmd_data[addr_width_p-1:0];
  assign hdr_op   = op_e'(cmd_data[addr_width_p +: 2]);
  assign hdr_len  = cmd_data[addr_width_p + 2 +: 3];

  // Latched packet context
  logic [addr_width_p-1:0] addr_r;
  op_e                     op_r;
  logic [2:0]              len_r;
  logic [2:0]              count_r;
  logic [flit_width_p-1:0] rd_data_r;

  // Backing store (not reset)
  logic [flit_width_p-1:0] mem [0:els_p-1];

  logic [lg_els_lp-1:0]    word_idx;
  logic                    last_word;
  op_e                     resp_op;
  logic [flit_width_p-1:0] resp_hdr;

  assign word_idx  = addr_r[byte_off_lp +: lg_els_lp] + lg_els_lp'(count_r);
  assign last_word = (count_r == len_r);
  assign resp_op   = (op_r == e_op_read || op_r == e_op_write) ? op_r : e_op_ill3;
  assign resp_hdr  = flit_width_p'({len_r, resp_op, addr_r});

  logic                    cmd_ready;
  logic                    resp_v;
  logic [flit_width_p-1:0] resp_data;
  logic                    cmd_hs;
  logic                    resp_hs;

  assign cmd_hs  = cmd_v & cmd_ready;
  assign resp_hs = resp_v & resp_ready;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ready;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and link outputs; all outputs forced low while in reset
  always_comb begin
    state_n   = state_r;
    cmd_ready = 1'b0;
    resp_v    = 1'b0;
    resp_data = '0;
    case (state_r)
      e_ready: begin
        cmd_ready = 1'b1;
        if (cmd_v) begin
          state_n = (hdr_op == e_op_write) ? e_wr_data : e_resp_hdr;
        end
      end
      e_wr_data: begin
        cmd_ready = 1'b1;
        if (cmd_v && last_word) begin
          state_n = e_resp_hdr;
        end
      end
      e_resp_hdr: begin
        resp_v    = 1'b1;
        resp_data = resp_hdr;
        if (resp_ready) begin
          state_n = (op_r == e_op_read) ? e_rd_req : e_ready;
        end
      end
      e_rd_req: begin
        state_n = e_rd_data;
      end
      e_rd_data: begin
        resp_v    = 1'b1;
        resp_data = rd_data_r;
        if (resp_ready) begin
          state_n = last_word ? e_ready : e_rd_req;
        end
      end
      default: begin
        state_n = e_ready;
      end
    endcase
    if (reset_i) begin
      cmd_ready = 1'b0;
      resp_v    = 1'b0;
      resp_data = '0;
    end
  end

  // Packet context: latch header fields and advance the burst counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_r  <= '0;
      op_r    <= e_op_read;
      len_r   <= '0;
      count_r <= '0;
    end else begin
      if (state_r == e_ready && cmd_hs) begin
        addr_r  <= hdr_addr;
        op_r    <= hdr_op;
        len_r   <= hdr_len;
        count_r <= '0;
      end else if (state_r == e_wr_data && cmd_hs) begin
        count_r <= count_r + 3'd1;
      end else if (state_r == e_rd_data && resp_hs) begin
        count_r <= count_r + 3'd1;
      end
    end
  end

  // Store write on accepted data flits; synchronous read in e_rd_req
  always_ff @(posedge clk_i) begin
    if (state_r == e_wr_data && cmd_hs) begin
      mem[word_idx] <= cmd_data;
    end
    if (state_r == e_rd_req) begin
      rd_data_r <= mem[word_idx];
    end
  end

  assign cmd_link_o  = {1'b0, {flit_width_p{1'b0}}, cmd_ready};
  assign resp_link_o = {resp_v, resp_data, 1'b0};

endmodule
